// File: rtl/fifo_word_reader_pkg.sv
// fifo_word_reader_pkg
//   Shared types and helpers for the FIFO word packer and the matching
//   writer-side unpacker.
//   - state_t   : FILL (collecting entries) / HOLD (word presented)
//   - keep_mask : returns a mask with the n low bits set (n up to 32)
package fifo_word_reader_pkg;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam int KEEP_MAX = 32;

  // n-low-bits-set mask. Callers truncate to their own lane count, so the
  // result is sized for the widest supported word.
  function automatic logic [KEEP_MAX-1:0] keep_mask(input int unsigned n);
    logic [KEEP_MAX-1:0] one;
    one = {{(KEEP_MAX-1){1'b0}}, 1'b1};
    if (n >= KEEP_MAX) return '1;
    return (one << n) - one;
  endfunction

endpackage

// File: rtl/fifo_word_reader.sv
// fifo_word_reader
//   Drains a first-word-fall-through FIFO and packs WORD_BYTES consecutive
//   entries little-endian into one word, presented on a valid/ready stream.
//   A flush closes a partial word, which carries a keep mask and last marker.
// Ports:
//   i_clk, i_rst         clock, synchronous active-high reset
//   i_empty, i_data      FIFO read side (head entry valid when !i_empty)
//   o_pop                FIFO pop strobe (combinational)
//   i_flush              single-cycle request to close the pending word
//   o_valid, i_ready     output stream handshake
//   o_data, o_keep       packed word and per-lane valid mask
//   o_last, o_count      word closed by flush / number of valid entries
module fifo_word_reader
  import fifo_word_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int WORD_BYTES = 4,
  localparam int CNT_WIDTH = $clog2(WORD_BYTES)
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_empty,
  input  logic [DATA_WIDTH-1:0]            i_data,
  output logic                             o_pop,
  input  logic                             i_flush,
  output logic                             o_valid,
  input  logic                             i_ready,
  output logic [DATA_WIDTH*WORD_BYTES-1:0] o_data,
  output logic [WORD_BYTES-1:0]            o_keep,
  output logic                             o_last,
  output logic [CNT_WIDTH:0]               o_count
);

  state_t                state_reg;
  logic [CNT_WIDTH-1:0]  cnt_reg;
  logic [WORD_BYTES-1:0] keep_reg;
  logic                  last_reg;
  logic [CNT_WIDTH:0]    count_reg;
  logic [DATA_WIDTH-1:0] lane_reg [WORD_BYTES];

  logic                  pop;
  logic                  fill_last_lane;
  logic                  handshake;
  logic [CNT_WIDTH:0]    n_total;

  assign pop            = (state_reg == FILL) && !i_empty && !i_rst;
  assign fill_last_lane = pop && (cnt_reg == CNT_WIDTH'(WORD_BYTES - 1));
  assign handshake      = (state_reg == HOLD) && i_ready;
  // Entries in the word if it were closed this cycle, including a
  // coincident pop.
  assign n_total        = {1'b0, cnt_reg} + (CNT_WIDTH + 1)'(pop);

  assign o_pop   = pop;
  assign o_valid = (state_reg == HOLD);
  assign o_keep  = keep_reg;
  assign o_last  = last_reg;
  assign o_count = count_reg;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg <= FILL;
      cnt_reg   <= '0;
      keep_reg  <= '0;
      last_reg  <= 1'b0;
      count_reg <= '0;
    end else begin
      case (state_reg)
        FILL: begin
          if (fill_last_lane) begin
            // A flush on the filling pop just marks the full word as last.
            state_reg <= HOLD;
            cnt_reg   <= '0;
            keep_reg  <= '1;
            count_reg <= (CNT_WIDTH + 1)'(WORD_BYTES);
            last_reg  <= i_flush;
          end else if (i_flush && (n_total != '0)) begin
            state_reg <= HOLD;
            cnt_reg   <= '0;
            keep_reg  <= WORD_BYTES'(keep_mask(32'(n_total)));
            count_reg <= n_total;
            last_reg  <= 1'b1;
          end else if (pop) begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        HOLD: begin
          if (i_ready) begin
            state_reg <= FILL;
            keep_reg  <= '0;
            count_reg <= '0;
            last_reg  <= 1'b0;
          end
        end
        default: state_reg <= FILL;
      endcase
    end
  end

  // Lane register file: each lane loads on a pop aimed at it and clears on
  // the handshake, so lanes past a partial word always read zero.
  generate
    for (genvar gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
      always_ff @(posedge i_clk) begin
        if (i_rst || handshake) begin
          lane_reg[gi] <= '0;
        end else if (pop && (cnt_reg == CNT_WIDTH'(gi))) begin
          lane_reg[gi] <= i_data;
        end
      end

      // The word is only driven while presented.
      assign o_data[gi*DATA_WIDTH +: DATA_WIDTH] =
        (state_reg == HOLD) ? lane_reg[gi] : '0;
    end
  endgenerate

endmodule
